// File: rtl/divide.sv
// Iterative signed divider: one restoring quotient bit per clock, with exceptions for divide-by-zero and overflow.
// Defining DIV_REMAINDER_EN adds the registered data_remainder output.
module divide #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_resultRDY,
`ifdef DIV_REMAINDER_EN
    output logic [WIDTH-1:0] data_remainder,
`endif
    output logic             data_exception
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_r, state_s;
    logic [CW-1:0]      cnt_r;
    logic [WIDTH:0]     rem_r;
    logic [WIDTH-1:0]   quot_r;
    logic [WIDTH-1:0]   div_r;
    logic               sign_q_r;
    logic               exc_pend_r;
    logic               div0_r;
`ifdef DIV_REMAINDER_EN
    logic               sign_r_r;
    logic [WIDTH-1:0]   rem_fix_s;
`endif

    logic [WIDTH-1:0]   abs_a_s, abs_b_s, quot_fix_s;
    logic               is_div0_s, is_ovf_s;
    logic [WIDTH+1:0]   shifted_s, trial_s;

    // Operand magnitudes, exception detection and one restoring step
    always_comb begin
        abs_a_s    = data_operandA[WIDTH-1] ? (~data_operandA + {{(WIDTH-1){1'b0}}, 1'b1}) : data_operandA;
        abs_b_s    = data_operandB[WIDTH-1] ? (~data_operandB + {{(WIDTH-1){1'b0}}, 1'b1}) : data_operandB;
        is_div0_s  = (data_operandB == {WIDTH{1'b0}});
        is_ovf_s   = (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (data_operandB == {WIDTH{1'b1}});
        // Two extra bits keep the borrow of the trial subtraction visible in the MSB
        shifted_s  = {rem_r, quot_r[WIDTH-1]};
        trial_s    = shifted_s - {2'b00, div_r};
        quot_fix_s = sign_q_r ? (~quot_r + {{(WIDTH-1){1'b0}}, 1'b1}) : quot_r;
`ifdef DIV_REMAINDER_EN
        rem_fix_s  = sign_r_r ? (~rem_r[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, 1'b1}) : rem_r[WIDTH-1:0];
`endif
    end

    // Next-state logic; a start edge overrides whatever is in flight
    always_comb begin
        state_s = state_r;
        if (ctrl_DIV) begin
            if (is_div0_s || is_ovf_s) begin
                state_s = DONE;
            end else begin
                state_s = RUN;
            end
        end else begin
            case (state_r)
                IDLE:    state_s = IDLE;
                RUN:     state_s = (cnt_r == CW'(1)) ? DONE : RUN;
                DONE:    state_s = IDLE;
                default: state_s = IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_r          <= {CW{1'b0}};
            rem_r          <= {(WIDTH+1){1'b0}};
            quot_r         <= {WIDTH{1'b0}};
            div_r          <= {WIDTH{1'b0}};
            sign_q_r       <= 1'b0;
            exc_pend_r     <= 1'b0;
            div0_r         <= 1'b0;
            data_result    <= {WIDTH{1'b0}};
            data_resultRDY <= 1'b0;
            data_exception <= 1'b0;
`ifdef DIV_REMAINDER_EN
            sign_r_r       <= 1'b0;
            data_remainder <= {WIDTH{1'b0}};
`endif
        end else begin
            data_resultRDY <= 1'b0;
            if (ctrl_DIV) begin
                cnt_r          <= CW'(WIDTH);
                rem_r          <= {(WIDTH+1){1'b0}};
                div_r          <= abs_b_s;
                sign_q_r       <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                exc_pend_r     <= is_div0_s || is_ovf_s;
                div0_r         <= is_div0_s;
                data_exception <= 1'b0;
                // Exceptional cases keep the raw dividend: it is the overflow quotient and the div-by-zero remainder
                quot_r         <= (is_div0_s || is_ovf_s) ? data_operandA : abs_a_s;
`ifdef DIV_REMAINDER_EN
                sign_r_r       <= data_operandA[WIDTH-1];
`endif
            end else begin
                case (state_r)
                    RUN: begin
                        cnt_r  <= cnt_r - CW'(1);
                        rem_r  <= trial_s[WIDTH+1] ? shifted_s[WIDTH:0] : trial_s[WIDTH:0];
                        quot_r <= {quot_r[WIDTH-2:0], ~trial_s[WIDTH+1]};
                    end
                    DONE: begin
                        data_resultRDY <= 1'b1;
                        if (exc_pend_r) begin
                            data_exception <= 1'b1;
                            data_result    <= div0_r ? {WIDTH{1'b0}} : quot_r;
`ifdef DIV_REMAINDER_EN
                            data_remainder <= div0_r ? quot_r : {WIDTH{1'b0}};
`endif
                        end else begin
                            data_result    <= quot_fix_s;
`ifdef DIV_REMAINDER_EN
                            data_remainder <= rem_fix_s;
`endif
                        end
                    end
                    default: begin
                        cnt_r <= cnt_r;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_divide.sv
// Self-checking bench for divide: directed cases plus random operands against a plain-arithmetic model.
module tb_divide;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_operandA = 32'd0;
    logic [31:0] data_operandB = 32'd0;
    logic [31:0] data_result;
    logic        data_resultRDY;
    logic        data_exception;
`ifdef DIV_REMAINDER_EN
    logic [31:0] data_remainder;
`endif

    int tests = 0;
    int fails = 0;

    divide #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_resultRDY (data_resultRDY),
`ifdef DIV_REMAINDER_EN
        .data_remainder (data_remainder),
`endif
        .data_exception (data_exception)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: signed arithmetic straight from the operation's definition
    task automatic model(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r,
                         output logic exc, output int lat);
        int sa, sb;
        sa = a;
        sb = b;
        if (b == 32'd0) begin
            q = 32'd0; r = a; exc = 1'b1; lat = 1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000; r = 32'd0; exc = 1'b1; lat = 1;
        end else begin
            q = sa / sb; r = sa % sb; exc = 1'b0; lat = 33;
        end
    endtask

    task automatic pulse(input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        ctrl_DIV = 1'b1;
        data_operandA = a;
        data_operandB = b;
        @(negedge clock);
        ctrl_DIV = 1'b0;
    endtask

    // Waits for RDY (bounded) and returns the number of edges since the start edge
    task automatic wait_rdy(output int n);
        n = 0;
        while (n < 60) begin
            @(posedge clock);
            n++;
            @(negedge clock);
            if (data_resultRDY === 1'b1) break;
        end
    endtask

    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [31:0] q, r;
        logic        exc;
        int          lat, n;
        model(a, b, q, r, exc, lat);
        pulse(a, b);
        check({tag, "_exc_clr"}, {63'd0, data_exception}, 64'd0);
        wait_rdy(n);
        check({tag, "_lat"}, 64'(n), 64'(lat));
        check({tag, "_q"}, {32'd0, data_result}, {32'd0, q});
        check({tag, "_exc"}, {63'd0, data_exception}, {63'd0, exc});
`ifdef DIV_REMAINDER_EN
        check({tag, "_r"}, {32'd0, data_remainder}, {32'd0, r});
`endif
        @(negedge clock);
        check({tag, "_rdy_1cyc"}, {63'd0, data_resultRDY}, 64'd0);
        check({tag, "_exc_hold"}, {63'd0, data_exception}, {63'd0, exc});
    endtask

    initial begin
        int n, seen;
        logic [31:0] a, b;

        // Reset state
        repeat (2) @(negedge clock);
        reset = 1'b0;
        check("rst_q", {32'd0, data_result}, 64'd0);
        check("rst_rdy", {63'd0, data_resultRDY}, 64'd0);
        check("rst_exc", {63'd0, data_exception}, 64'd0);

        // Directed cases
        do_div(32'd12, 32'hFFFF_FFFD, "12_by_m3");
        do_div(32'hFFFF_FFF9, 32'd2, "m7_by_2");
        do_div(32'd7, 32'd0, "div0");
        repeat (5) @(negedge clock);
        check("div0_exc_sticky", {63'd0, data_exception}, 64'd1);
        do_div(32'h8000_0000, 32'hFFFF_FFFF, "ovf");
        do_div(32'h8000_0000, 32'd1, "min_by_1");
        do_div(32'h8000_0000, 32'h8000_0000, "min_by_min");
        do_div(32'h7FFF_FFFF, 32'h8000_0000, "max_by_min");
        do_div(32'd0, 32'd5, "zero_by_5");

        // Restart mid-run: first operation must never report
        pulse(32'd100, 32'd7);
        seen = 0;
        repeat (9) begin
            @(negedge clock);
            if (data_resultRDY === 1'b1) seen++;
        end
        check("restart_no_rdy", 64'(seen), 64'd0);
        do_div(32'd50, 32'd5, "restart_50_by_5");

        // Reset aborts a division in flight
        pulse(32'd1000, 32'd3);
        repeat (13) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("abort_q", {32'd0, data_result}, 64'd0);
        check("abort_exc", {63'd0, data_exception}, 64'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clock);
            if (data_resultRDY === 1'b1) seen++;
        end
        check("abort_no_rdy", 64'(seen), 64'd0);

        // Random operands, with some small and zero divisors mixed in
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            case (i % 4)
                0:       b = $urandom;
                1:       b = 32'($urandom_range(0, 9));
                2:       b = -32'($urandom_range(1, 9));
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            do_div(a, b, $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/divide.md
Name: divide

Overview:
- Iterative signed integer divider, the inverse operation to the team's multicycle multiplier in the ALU multdiv unit.
- Uses one non-restoring (or restoring) quotient bit per clock.
- Shares the operand, control, ready and exception signalling of the multiplier, so the multdiv wrapper can mux the two units on data_result / data_resultRDY / data_exception.

Parameters:
- WIDTH, 32, operand/quotient width in bits (two's complement); latency scales with it.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- ctrl_DIV  input  1  start pulse; operands sampled on the same edge
- data_operandA  input  WIDTH  dividend (signed)
- data_operandB  input  WIDTH  divisor (signed)
- data_result  output  WIDTH  quotient, registered
- data_resultRDY  output  1  one-cycle pulse: result/exception valid
- data_exception  output  1  divide-by-zero or overflow flag, registered

Behaviour:
- Reset: reset=1 on a rising edge forces state IDLE and data_result=0, data_resultRDY=0, data_exception=0. All internal counters and registers clear. Reset has priority over ctrl_DIV and aborts any division in flight; no RDY pulse is produced for an aborted operation.
- States: IDLE, RUN, DONE.
- Start, edge k (ctrl_DIV=1, reset=0), from any state:
  - latch |A|, |B|, sign_q = A[W-1]^B[W-1], sign_r = A[W-1];
  - load counter = WIDTH; clear data_exception; go to RUN.
  - data_result holds its previous value until completion.
- RUN: one quotient bit per edge, MSB first, using a (WIDTH+1)-bit partial-remainder register. The counter decrements each edge. When the counter reaches 0, go to DONE.
- DONE (one cycle):
  - apply sign correction: quotient negated if sign_q; remainder negated if sign_r;
  - register data_result; assert data_resultRDY for exactly one cycle; return to IDLE.
- Latency: data_resultRDY is high in the cycle following edge k+WIDTH+1 (33 edges after start for WIDTH=32).
- Quotient truncates toward zero. Remainder sign follows the dividend.
- Divide by zero (B==0 at start):
  - skip RUN; at edge k+1 assert data_resultRDY=1, data_exception=1, data_result=0;
  - return to IDLE.
- Overflow (A = -2^(W-1), B = -1):
  - skip RUN; at edge k+1 assert data_resultRDY=1, data_exception=1, data_result = -2^(W-1) (0x80000000);
  - return to IDLE.
- data_exception holds after RDY until the next start or reset.
- ctrl_DIV during RUN/DONE: current operation is discarded with no RDY pulse. New operands are latched and the full latency restarts from that edge.
- ctrl_DIV held high for multiple cycles: each high edge is a fresh start, so RDY only occurs after it drops. The wrapper must pulse it.
- Single-edge ctrl_DIV in the same cycle as DONE: restart wins and no RDY pulse is produced.
- Magnitude of -2^(W-1) is handled as an unsigned WIDTH-bit value (no truncation).

Optional Feature:
- Macro: DIV_REMAINDER_EN.
- Defined:
  - adds output port data_remainder (WIDTH bits, registered);
  - reset value 0; updated in DONE alongside data_result;
  - sign follows the dividend;
  - divide by zero gives data_remainder = dividend; overflow gives data_remainder = 0.
- Undefined: port absent; the remainder register is retained only as much as the algorithm requires, with no extra output logic.

Test Plan:
- A=12, B=-3, one-cycle ctrl_DIV at edge k -> RDY high only after edge k+33; result=0xFFFFFFFC (-4); exception=0. With DIV_REMAINDER_EN, remainder=0.
- A=-7, B=2 -> result=0xFFFFFFFD (-3), exception=0. With DIV_REMAINDER_EN, remainder=0xFFFFFFFF (-1).
- A=7, B=0 -> RDY after edge k+1, exception=1, result=0. Exception stays 1 until the next ctrl_DIV edge, then clears.
- A=0x80000000, B=0xFFFFFFFF -> RDY after edge k+1, exception=1, result=0x80000000. Then A=0x80000000, B=1 -> result=0x80000000, exception=0, 33-cycle latency.
- Start 100/7, re-pulse ctrl_DIV with 50/5 at cycle 10 -> no RDY for the first operation; RDY 33 edges after the second pulse with result=10.
- Start 1000/3; assert reset at cycle 15 -> all outputs 0 on the next edge; no RDY appears within the following 40 cycles.
